// File: rtl/ex_stage_muldiv.sv
// Execute stage: ALU, branch resolution and target, and an iterative RV32M-style mul/div unit.
// All outputs are registered and form the EX/MEM pipeline register.
module ex_stage_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] rd1_ex,
  input  logic [XLEN-1:0] rd2_ex,
  input  logic [XLEN-1:0] imm_ex,
  input  logic            alu_src_ex,
  input  logic [3:0]      alu_ctrl_ex,
  input  logic [2:0]      branch_cond_ex,
  input  logic            jump_ex,
  input  logic            muldiv_en_ex,
  input  logic [2:0]      muldiv_op_ex,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] pc_branch,
  output logic            take_branch
);

  localparam int unsigned CntW = $clog2(XLEN + 1);
  localparam int unsigned ShW  = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [XLEN-1:0]     rem_q, rem_d, quo_q, quo_d, divisor_q, divisor_d;
  logic                neg_q, neg_d, rneg_q, rneg_d;
  logic [2:0]          op_q, op_d;
  logic                out_valid_q, out_valid_d, take_branch_q, take_branch_d;
  logic [XLEN-1:0]     alu_result_q, alu_result_d, store_data_q, store_data_d;
  logic [XLEN-1:0]     pc_branch_q, pc_branch_d;

  // ALU encoding: {funct7[5], funct3} of the RV32I register ops.
  logic [XLEN-1:0] op_b, alu_out;
  logic [ShW-1:0]  shamt;

  assign op_b  = alu_src_ex ? imm_ex : rd2_ex;
  assign shamt = op_b[ShW-1:0];

  always_comb begin
    alu_out = '0;
    case (alu_ctrl_ex)
      4'b0000: alu_out = rd1_ex + op_b;
      4'b1000: alu_out = rd1_ex - op_b;
      4'b0001: alu_out = rd1_ex << shamt;
      4'b0010: alu_out = {{(XLEN-1){1'b0}}, $signed(rd1_ex) < $signed(op_b)};
      4'b0011: alu_out = {{(XLEN-1){1'b0}}, rd1_ex < op_b};
      4'b0100: alu_out = rd1_ex ^ op_b;
      4'b0101: alu_out = rd1_ex >> shamt;
      4'b1101: alu_out = $signed(rd1_ex) >>> shamt;
      4'b0110: alu_out = rd1_ex | op_b;
      4'b0111: alu_out = rd1_ex & op_b;
      default: alu_out = '0;
    endcase
  end

  logic br_met;
  always_comb begin
    br_met = 1'b0;
    case (branch_cond_ex)
      3'b001:  br_met = (rd1_ex == rd2_ex);
      3'b010:  br_met = (rd1_ex != rd2_ex);
      3'b011:  br_met = ($signed(rd1_ex) < $signed(rd2_ex));
      3'b100:  br_met = ($signed(rd1_ex) >= $signed(rd2_ex));
      3'b101:  br_met = (rd1_ex < rd2_ex);
      3'b110:  br_met = (rd1_ex >= rd2_ex);
      default: br_met = 1'b0;
    endcase
  end

  // Operand signedness: MUL/MULH/MULHSU sign rs1, MUL/MULH sign rs2, DIV/REM sign both.
  logic            sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  assign sgn_a    = muldiv_op_ex[2] ? ~muldiv_op_ex[0] : (muldiv_op_ex[1:0] != 2'b11);
  assign sgn_b    = muldiv_op_ex[2] ? ~muldiv_op_ex[0] : ~muldiv_op_ex[1];
  assign neg_a    = sgn_a & rd1_ex[XLEN-1];
  assign neg_b    = sgn_b & rd2_ex[XLEN-1];
  assign mag_a    = neg_a ? -rd1_ex : rd1_ex;
  assign mag_b    = neg_b ? -rd2_ex : rd2_ex;
  assign div_zero = (rd2_ex == '0);
  assign div_ovf  = sgn_a & (rd1_ex == MinNeg) & (rd2_ex == '1);

  // One shift-add step and one restoring shift-subtract step.
  logic [2*XLEN-1:0] mul_acc_nx, mul_prod;
  logic [XLEN-1:0]   mul_res, rem_nx, quo_nx, div_res;
  logic [XLEN:0]     rem_sh;
  logic              div_ge;

  assign mul_acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_prod   = neg_q ? -mul_acc_nx : mul_acc_nx;
  assign mul_res    = (op_q == 3'b000) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  assign rem_sh     = {rem_q, quo_q[XLEN-1]};
  assign div_ge     = (rem_sh >= {1'b0, divisor_q});
  assign rem_nx     = div_ge ? (rem_sh[XLEN-1:0] - divisor_q) : rem_sh[XLEN-1:0];
  assign quo_nx     = {quo_q[XLEN-2:0], div_ge};
  assign div_res    = op_q[1] ? (rneg_q ? -rem_nx : rem_nx) : (neg_q ? -quo_nx : quo_nx);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    divisor_d     = divisor_q;
    neg_d         = neg_q;
    rneg_d        = rneg_q;
    op_d          = op_q;
    out_valid_d   = 1'b0;
    alu_result_d  = alu_result_q;
    store_data_d  = store_data_q;
    pc_branch_d   = pc_branch_q;
    take_branch_d = take_branch_q;

    if (flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            store_data_d = rd2_ex;
            pc_branch_d  = pc_ex + imm_ex;
            op_d         = muldiv_op_ex;
            if (!muldiv_en_ex) begin
              alu_result_d  = alu_out;
              take_branch_d = br_met | jump_ex;
              out_valid_d   = 1'b1;
            end else begin
              take_branch_d = 1'b0;
              if (!muldiv_op_ex[2]) begin
                acc_d    = '0;
                mcand_d  = {{XLEN{1'b0}}, mag_a};
                mplier_d = mag_b;
                neg_d    = neg_a ^ neg_b;
                cnt_d    = CntW'(XLEN);
                state_d  = StMul;
              end else if (div_zero) begin
                alu_result_d = muldiv_op_ex[1] ? rd1_ex : '1;
                out_valid_d  = 1'b1;
              end else if (div_ovf) begin
                alu_result_d = muldiv_op_ex[1] ? '0 : rd1_ex;
                out_valid_d  = 1'b1;
              end else begin
                rem_d     = '0;
                quo_d     = mag_a;
                divisor_d = mag_b;
                neg_d     = neg_a ^ neg_b;
                rneg_d    = neg_a;
                cnt_d     = CntW'(XLEN);
                state_d   = StDiv;
              end
            end
          end
        end
        StMul: begin
          acc_d    = mul_acc_nx;
          mcand_d  = {mcand_q[2*XLEN-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[XLEN-1:1]};
          cnt_d    = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            alu_result_d = mul_res;
            out_valid_d  = 1'b1;
            state_d      = StIdle;
          end
        end
        StDiv: begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            alu_result_d = div_res;
            out_valid_d  = 1'b1;
            state_d      = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      divisor_q     <= '0;
      neg_q         <= 1'b0;
      rneg_q        <= 1'b0;
      op_q          <= '0;
      out_valid_q   <= 1'b0;
      alu_result_q  <= '0;
      store_data_q  <= '0;
      pc_branch_q   <= '0;
      take_branch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      divisor_q     <= divisor_d;
      neg_q         <= neg_d;
      rneg_q        <= rneg_d;
      op_q          <= op_d;
      out_valid_q   <= out_valid_d;
      alu_result_q  <= alu_result_d;
      store_data_q  <= store_data_d;
      pc_branch_q   <= pc_branch_d;
      take_branch_q <= take_branch_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = out_valid_q;
  assign alu_result  = alu_result_q;
  assign store_data  = store_data_q;
  assign pc_branch   = pc_branch_q;
  assign take_branch = take_branch_q;

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Self-checking bench for ex_stage_muldiv: directed vector table, randomized ops against a
// plain-arithmetic reference model, and flush / reset-mid-operation sequences.
module tb_ex_stage_muldiv;
  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, flush;
  logic [XLEN-1:0] pc_ex, rd1_ex, rd2_ex, imm_ex;
  logic            alu_src_ex, jump_ex, muldiv_en_ex;
  logic [3:0]      alu_ctrl_ex;
  logic [2:0]      branch_cond_ex, muldiv_op_ex;
  logic            out_valid, take_branch;
  logic [XLEN-1:0] alu_result, store_data, pc_branch;

  ex_stage_muldiv #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .pc_ex(pc_ex), .rd1_ex(rd1_ex), .rd2_ex(rd2_ex), .imm_ex(imm_ex),
    .alu_src_ex(alu_src_ex), .alu_ctrl_ex(alu_ctrl_ex), .branch_cond_ex(branch_cond_ex),
    .jump_ex(jump_ex), .muldiv_en_ex(muldiv_en_ex), .muldiv_op_ex(muldiv_op_ex),
    .out_valid(out_valid), .alu_result(alu_result), .store_data(store_data),
    .pc_branch(pc_branch), .take_branch(take_branch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, rd1, rd2, imm;
    logic        alu_src;
    logic [3:0]  ctrl;
    logic [2:0]  cond;
    logic        jump, md_en;
    logic [2:0]  md_op;
  } op_t;

  typedef struct {
    logic [31:0] res;
    logic        take;
    int          lat;
  } exp_t;

  typedef struct {
    string name;
    op_t   op;
    exp_t  e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  task automatic chk(input string tag, input string what, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h, expected %0h", tag, what, act, exp);
    end
  endtask

  function automatic op_t mk(logic [31:0] pc, logic [31:0] rd1, logic [31:0] rd2,
                             logic [31:0] imm, logic src, logic [3:0] ctrl, logic [2:0] cond,
                             logic jump, logic en, logic [2:0] mop);
    op_t o;
    o.pc = pc; o.rd1 = rd1; o.rd2 = rd2; o.imm = imm; o.alu_src = src; o.ctrl = ctrl;
    o.cond = cond; o.jump = jump; o.md_en = en; o.md_op = mop;
    return o;
  endfunction

  task automatic add_vec(input string n, input op_t o, input logic [31:0] r, input logic t,
                         input int l);
    vec_t v;
    v.name = n; v.op = o; v.e.res = r; v.e.take = t; v.e.lat = l;
    tbl.push_back(v);
  endtask

  // Reference model: results from plain wide arithmetic on the architectural rules.
  function automatic exp_t model(op_t o);
    exp_t             e;
    logic [31:0]      b;
    logic signed [65:0] a66, b66, p;
    longint           na, nb, q, r;
    e.res = '0; e.take = 1'b0; e.lat = 0;
    if (!o.md_en) begin
      b = o.alu_src ? o.imm : o.rd2;
      case (o.ctrl)
        4'd0:    e.res = o.rd1 + b;
        4'd8:    e.res = o.rd1 - b;
        4'd1:    e.res = o.rd1 << b[4:0];
        4'd2:    e.res = ($signed(o.rd1) < $signed(b)) ? 32'd1 : 32'd0;
        4'd3:    e.res = (o.rd1 < b) ? 32'd1 : 32'd0;
        4'd4:    e.res = o.rd1 ^ b;
        4'd5:    e.res = o.rd1 >> b[4:0];
        4'd13:   e.res = 32'($signed(o.rd1) >>> b[4:0]);
        4'd6:    e.res = o.rd1 | b;
        4'd7:    e.res = o.rd1 & b;
        default: e.res = '0;
      endcase
      case (o.cond)
        3'd1:    e.take = (o.rd1 == o.rd2);
        3'd2:    e.take = (o.rd1 != o.rd2);
        3'd3:    e.take = ($signed(o.rd1) < $signed(o.rd2));
        3'd4:    e.take = ($signed(o.rd1) >= $signed(o.rd2));
        3'd5:    e.take = (o.rd1 < o.rd2);
        3'd6:    e.take = (o.rd1 >= o.rd2);
        default: e.take = 1'b0;
      endcase
      e.take = e.take | o.jump;
    end else if (!o.md_op[2]) begin
      a66 = (o.md_op != 3'd3 && o.rd1[31]) ? {34'h3FFFFFFFF, o.rd1} : {34'h0, o.rd1};
      b66 = (!o.md_op[1] && o.rd2[31]) ? {34'h3FFFFFFFF, o.rd2} : {34'h0, o.rd2};
      p = a66 * b66;
      e.res = (o.md_op == 3'd0) ? p[31:0] : p[63:32];
      e.lat = 32;
    end else begin
      na = o.md_op[0] ? longint'(o.rd1) : longint'($signed(o.rd1));
      nb = o.md_op[0] ? longint'(o.rd2) : longint'($signed(o.rd2));
      if (nb == 0) begin
        q = -1; r = na; e.lat = 0;
      end else begin
        q = na / nb; r = na % nb;
        e.lat = (!o.md_op[0] && na == -64'sd2147483648 && nb == -64'sd1) ? 0 : 32;
      end
      e.res = o.md_op[1] ? r[31:0] : q[31:0];
    end
    return e;
  endfunction

  function automatic logic [31:0] rval();
    case ($urandom % 6)
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  function automatic op_t rand_op();
    int codes[10] = '{0, 8, 1, 2, 3, 4, 5, 13, 6, 7};
    return mk($urandom, rval(), rval(), rval(), 1'($urandom % 2), 4'(codes[$urandom % 10]),
              3'($urandom % 8), ($urandom % 5) == 0, ($urandom % 3) == 0, 3'($urandom % 8));
  endfunction

  task automatic drive(input op_t o);
    pc_ex = o.pc; rd1_ex = o.rd1; rd2_ex = o.rd2; imm_ex = o.imm; alu_src_ex = o.alu_src;
    alu_ctrl_ex = o.ctrl; branch_cond_ex = o.cond; jump_ex = o.jump;
    muldiv_en_ex = o.md_en; muldiv_op_ex = o.md_op;
  endtask

  // Present one instruction, then wait (bounded) for its result; lat counts edges after accept.
  task automatic run_check(input string tag, input op_t o, input exp_t e);
    int          lat;
    logic        busy_ok;
    logic [31:0] pcb;
    @(negedge clk);
    drive(o);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    pcb = o.pc + o.imm;
    chk(tag, "out_valid", 64'(out_valid), 64'd1);
    chk(tag, "alu_result", 64'(alu_result), 64'(e.res));
    chk(tag, "take_branch", 64'(take_branch), 64'(e.take));
    chk(tag, "pc_branch", 64'(pc_branch), 64'(pcb));
    chk(tag, "store_data", 64'(store_data), 64'(o.rd2));
    chk(tag, "latency", 64'(lat), 64'(e.lat));
    chk(tag, "busy_in_ready", 64'(busy_ok), 64'd1);
    chk(tag, "in_ready_done", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk(tag, "pulse", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    logic seen;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    chk("reset", "out_valid", 64'(out_valid), 64'd0);
    chk("reset", "take_branch", 64'(take_branch), 64'd0);
    chk("reset", "alu_result", 64'(alu_result), 64'd0);
    chk("reset", "store_data", 64'(store_data), 64'd0);
    chk("reset", "pc_branch", 64'(pc_branch), 64'd0);
    chk("reset", "in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    add_vec("add", mk(0, 5, 0, 7, 1, 4'd0, 0, 0, 0, 0), 32'd12, 0, 0);
    add_vec("blt", mk(32'h100, 32'hFFFF_FFFF, 1, 32'h20, 1, 4'd0, 3'd3, 0, 0, 0),
            32'h1F, 1, 0);
    add_vec("bltu", mk(32'h100, 32'hFFFF_FFFF, 1, 32'h20, 1, 4'd0, 3'd5, 0, 0, 0),
            32'h1F, 0, 0);
    add_vec("jump", mk(32'h100, 32'hFFFF_FFFF, 1, 32'h20, 1, 4'd0, 3'd0, 1, 0, 0),
            32'h1F, 1, 0);
    add_vec("beq", mk(32'h40, 3, 3, 32'hFFFF_FFF0, 0, 4'd8, 3'd1, 0, 0, 0), 32'd0, 1, 0);
    add_vec("sub", mk(0, 10, 3, 0, 0, 4'd8, 3'd2, 0, 0, 0), 32'd7, 1, 0);
    add_vec("sra", mk(0, 32'h8000_0000, 0, 4, 1, 4'd13, 0, 0, 0, 0), 32'hF800_0000, 0, 0);
    add_vec("mulh", mk(8, 32'h8000_0000, 32'h8000_0000, 4, 0, 0, 3'd1, 1, 1, 3'd1),
            32'h4000_0000, 0, 32);
    add_vec("mul", mk(0, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 0, 1, 3'd0), 32'd0, 0, 32);
    add_vec("mulhu", mk(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 3'd3),
            32'hFFFF_FFFE, 0, 32);
    add_vec("div_ovf", mk(0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 3'd4),
            32'h8000_0000, 0, 0);
    add_vec("rem_ovf", mk(0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 3'd6),
            32'd0, 0, 0);
    add_vec("divu_0", mk(0, 7, 0, 0, 0, 0, 0, 0, 1, 3'd5), 32'hFFFF_FFFF, 0, 0);
    add_vec("remu_0", mk(0, 7, 0, 0, 0, 0, 0, 0, 1, 3'd7), 32'd7, 0, 0);
    add_vec("div_neg", mk(0, 32'hFFFF_FFF9, 2, 0, 0, 0, 0, 0, 1, 3'd4), 32'hFFFF_FFFD, 0, 32);
    add_vec("rem_neg", mk(0, 32'hFFFF_FFF9, 2, 0, 0, 0, 0, 0, 1, 3'd6), 32'hFFFF_FFFF, 0, 32);

    foreach (tbl[i]) run_check(tbl[i].name, tbl[i].op, tbl[i].e);

    for (int i = 0; i < 300; i++) begin
      o = rand_op();
      run_check($sformatf("rnd%0d", i), o, model(o));
    end

    // Flush on the 10th iteration of DIVU 100/3.
    @(negedge clk);
    drive(mk(0, 100, 3, 0, 0, 0, 0, 0, 1, 3'd5));
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("flush", "busy", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush", "in_ready", 64'(in_ready), 64'd1);
    seen = out_valid;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush", "no_out_valid", 64'(seen), 64'd0);
    o = mk(32'h200, 9, 3, 4, 1, 4'd0, 0, 0, 0, 0);
    run_check("flush_add", o, model(o));

    // Asynchronous reset in the middle of a MUL.
    @(negedge clk);
    drive(mk(32'h40, 6, 3, 4, 0, 0, 0, 0, 1, 3'd0));
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid", "alu_result", 64'(alu_result), 64'd0);
    chk("rst_mid", "store_data", 64'(store_data), 64'd0);
    chk("rst_mid", "pc_branch", 64'(pc_branch), 64'd0);
    chk("rst_mid", "valid_take", 64'({out_valid, take_branch}), 64'd0);
    chk("rst_mid", "in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    o = mk(32'h300, 1, 2, 5, 0, 4'd0, 3'd5, 0, 0, 0);
    run_check("rst_add", o, model(o));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage_muldiv.md
# ex_stage_muldiv

Parametrised successor of the execute stage: XLEN-wide ALU, branch resolution and branch-target generation, plus an iterative RV M-extension multiply/divide unit. Sits between ID/EX and EX/MEM. Outputs are registered, so it also provides the EX/MEM output register. A valid/ready handshake stalls the upstream pipeline while a multi-cycle M operation runs.

## Interface
- `XLEN`, default 32: datapath width; must be an even value ≥ 8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  ID/EX holds a valid instruction.
- `in_ready`  out  1  stage can accept an instruction; equals state==IDLE.
- `flush`  in  1  synchronous kill of the in-flight instruction and the output register.
- `pc_ex`, `rd1_ex`, `rd2_ex`, `imm_ex`  in  XLEN  operands.
- `alu_src_ex`  in  1  selects ALU operand B: 1 = imm, 0 = rd2.
- `alu_ctrl_ex`  in  4  ALU operation, same encoding as the existing ALU module.
- `branch_cond_ex`  in  3  branch condition: 001 EQ, 010 NE, 011 LT, 100 GE, 101 LTU, 110 GEU; any other value means no branch.
- `jump_ex`  in  1  unconditional jump.
- `muldiv_en_ex`  in  1  instruction is an M-extension operation.
- `muldiv_op_ex`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `out_valid`  out  1  output register holds a result; high for exactly one cycle per instruction.
- `alu_result`  out  XLEN  ALU or M-unit result.
- `store_data`  out  XLEN  registered rd2.
- `pc_branch`  out  XLEN  registered pc+imm, modulo 2^XLEN.
- `take_branch`  out  1  registered (condition met) OR jump.

## Operation
- **FSM states:** IDLE, MUL, DIV.
- **Accept:** an instruction is accepted on an edge where in_valid & in_ready & !flush.
- **Non-M accept** (muldiv_en_ex = 0):
  - Output register loads the ALU result, rd2, pc+imm and take_branch.
  - out_valid = 1. FSM stays in IDLE.
- **Branch compare:** EQ/NE are bitwise. LT/GE are signed; LTU/GEU are unsigned.
- **M ops:**
  - take_branch = 0. pc_branch and store_data are still loaded as for non-M ops.
- **MUL-class accept:**
  - Latch operand magnitudes and the result sign. Signedness: MUL/MULH treat both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU treats both as unsigned.
  - Clear the 2·XLEN accumulator. Counter = XLEN. Go to MUL.
- **MUL state:**
  - Each cycle performs one shift-add step.
  - On the edge where the counter reaches 0: negate the product if needed; write the low half (MUL) or high half (others) to alu_result; set out_valid = 1; return to IDLE.
- **DIV-class accept:**
  - DIV/REM are signed; DIVU/REMU are unsigned.
  - **Divisor = 0 (early-out, one cycle, like a non-M op):** quotient = all-ones; remainder = dividend.
  - **Signed overflow, dividend = most-negative and divisor = −1 (early-out):** quotient = dividend; remainder = 0.
  - **Otherwise:** latch magnitudes, counter = XLEN, go to DIV.
- **DIV state:**
  - Each cycle performs one restoring shift-subtract step.
  - On the final edge: fix signs and write the result, then set out_valid = 1 and return to IDLE.
  - Quotient truncates toward zero. A nonzero remainder takes the dividend's sign.
- **Flush:** takes priority over accept and over iteration. On the next edge: state → IDLE, out_valid → 0, and any partial result is discarded.
- **No accept:** on an edge with no accept and no M-op completion, out_valid → 0. The data outputs hold their values.

## Timing
- **Reset values:** out_valid, take_branch, alu_result, store_data and pc_branch are all 0; state = IDLE, so in_ready = 1.
- **Reset mid-operation:** behaves identically; the operation is abandoned.
- **Non-M latency:** accept at edge k → out_valid is high in the cycle after edge k. Throughput is 1 per cycle.
- **MUL, and DIV without early-out:** accept at edge k → in_ready = 0 after edge k → result and out_valid after edge k+XLEN.
- **Back-to-back:** in_ready = 1 in the same cycle as out_valid, so the next instruction can be accepted at edge k+XLEN+1.
- **Early-out divide:** same latency as a non-M op.
- **in_ready:** combinational from the state only, with no path from in_valid. While in_ready = 0, upstream must hold its inputs; the stage ignores them.
- **Arithmetic:** all arithmetic is modulo 2^XLEN. No flags are produced.

## Test plan
- ALU add: rd1=5, imm=7, alu_src=1, ADD code → next cycle alu_result=12, out_valid=1, and in_ready never drops.
- Branch: pc=0x100, imm=0x20, rd1=0xFFFFFFFF, rd2=1.
  - cond=011 (LT) → take_branch=1, pc_branch=0x120.
  - cond=101 (LTU) → take_branch=0.
  - cond=000 with jump=1 → take_branch=1.
- MULH 0x80000000×0x80000000 → in_ready low for 32 cycles, then alu_result=0x40000000. MUL of the same operands → 0.
- DIV corner cases:
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000 after 1 cycle; REM of the same → 0.
  - DIVU 7/0 → 0xFFFFFFFF; REMU 7/0 → 7.
- Signed divide: DIV −7/2 → 0xFFFFFFFD after 32 cycles; REM −7/2 → 0xFFFFFFFF.
- Flush, then reset: flush at iteration 10 of DIVU 100/3 → out_valid never rises and in_ready=1 next cycle. A subsequent ADD completes normally. Repeat with rst asserted mid-op → all outputs 0 immediately.
